// File: rtl/cluster_accum_pipe3_if.sv
// Point-input and record-readout bus of the K-means accumulate stage (pipe 3).
// slave is the accumulator's view, master the producer/consumer side.
interface cluster_accum_pipe3_if #(
  parameter int unsigned dataWidth   = 91,
  parameter int unsigned accum_width = 154,
  parameter int unsigned count_width = 10
) ();
  logic [dataWidth-1:0]   point_from_pipe2;
  logic [3:0]             index;
  logic                   point_valid;
  logic                   in_ready;
  logic                   clear;
  logic                   dump_req;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [3:0]             dump_index;
  logic [accum_width-1:0] dump_accum;
  logic [count_width-1:0] dump_count;
  logic                   dump_done;
  logic                   overflow;
  logic                   index_err;

  modport slave (
    input  point_from_pipe2, index, point_valid, clear, dump_req, dump_ready,
    output in_ready, dump_valid, dump_index, dump_accum, dump_count, dump_done,
           overflow, index_err
  );

  modport master (
    output point_from_pipe2, index, point_valid, clear, dump_req, dump_ready,
    input  in_ready, dump_valid, dump_index, dump_accum, dump_count, dump_done,
           overflow, index_err
  );
endinterface

// File: rtl/cluster_accum_pipe3.sv
// K-means pipe stage 3: per-centroid saturating coordinate sums and member counts,
// streamed out as (sum, count) records. Define CLUSTER_ACCUM_SKIP_EMPTY_EN to skip empty slots.
module cluster_accum_pipe3 #(
  parameter int unsigned dataWidth        = 91,
  parameter int unsigned cordinate_width  = 13,
  parameter int unsigned coord_num        = 7,
  parameter int unsigned accum_cord_width = 22,
  parameter int unsigned accum_width      = 154,
  parameter int unsigned centroid_num     = 8,
  parameter int unsigned count_width      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cluster_accum_pipe3_if.slave  bus
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SLOT_W = $clog2(centroid_num);
  localparam int unsigned AW1    = accum_cord_width + 1;

  typedef enum logic [0:0] {ACCUM, DUMP} state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    dump_valid_q;
  logic [IDX_W-1:0]        dump_index_q;
  logic [accum_width-1:0]  dump_accum_q;
  logic [count_width-1:0]  dump_count_q;
  logic                    dump_done_q;
  logic                    overflow_q;
  logic                    index_err_q;

  logic [accum_width-1:0]  sum_q [centroid_num];
  logic [count_width-1:0]  cnt_q [centroid_num];
  logic [accum_width-1:0]  sum_d [centroid_num];
  logic [count_width-1:0]  cnt_d [centroid_num];

  logic [dataWidth-1:0]    point_c;
  logic                    legal_c;
  logic [SLOT_W-1:0]       slot_c;
  logic                    sat_c;
  logic                    bad_idx_c;
  logic                    first_ok_c;
  logic [SLOT_W-1:0]       first_slot_c;
  logic                    nxt_ok_c;
  logic [SLOT_W-1:0]       nxt_slot_c;

  assign point_c = bus.point_from_pipe2;
  assign legal_c = (bus.index != '0) && (bus.index <= IDX_W'(centroid_num));
  assign slot_c  = SLOT_W'(bus.index - IDX_W'(1));

  // Next slot contents: optional clear, then saturating add of an accepted point.
  always_comb begin
    logic [AW1-1:0] tmp;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    sat_c     = 1'b0;
    bad_idx_c = 1'b0;
    tmp       = '0;
    if (state_q == ACCUM) begin
      if (bus.clear) begin
        for (int i = 0; i < int'(centroid_num); i++) begin
          sum_d[i] = '0;
          cnt_d[i] = '0;
        end
      end
      if (bus.point_valid && in_ready_q) begin
        if (!legal_c) begin
          bad_idx_c = 1'b1;
        end else begin
          for (int c = 0; c < int'(coord_num); c++) begin
            tmp = {1'b0, sum_d[slot_c][c*accum_cord_width +: accum_cord_width]}
                + AW1'(point_c[c*cordinate_width +: cordinate_width]);
            if (tmp[AW1-1]) begin
              sat_c = 1'b1;
              sum_d[slot_c][c*accum_cord_width +: accum_cord_width] = '1;
            end else begin
              sum_d[slot_c][c*accum_cord_width +: accum_cord_width] = tmp[AW1-2:0];
            end
          end
          if (&cnt_d[slot_c]) begin
            sat_c = 1'b1;
          end else begin
            cnt_d[slot_c] = cnt_d[slot_c] + count_width'(1);
          end
        end
      end
    end
  end

  // Record selection: first record of a dump, and the record after the current one.
  always_comb begin
`ifdef CLUSTER_ACCUM_SKIP_EMPTY_EN
    first_ok_c   = 1'b0;
    first_slot_c = '0;
    nxt_ok_c     = 1'b0;
    nxt_slot_c   = '0;
    for (int i = 0; i < int'(centroid_num); i++) begin
      if (!first_ok_c && (cnt_d[i] != '0)) begin
        first_ok_c   = 1'b1;
        first_slot_c = SLOT_W'(i);
      end
      if (!nxt_ok_c && (IDX_W'(i) >= dump_index_q) && (cnt_q[i] != '0)) begin
        nxt_ok_c   = 1'b1;
        nxt_slot_c = SLOT_W'(i);
      end
    end
`else
    first_ok_c   = 1'b1;
    first_slot_c = '0;
    nxt_ok_c     = (dump_index_q < IDX_W'(centroid_num));
    nxt_slot_c   = SLOT_W'(dump_index_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      in_ready_q   <= 1'b1;
      dump_valid_q <= 1'b0;
      dump_index_q <= IDX_W'(1);
      dump_accum_q <= '0;
      dump_count_q <= '0;
      dump_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      index_err_q  <= 1'b0;
      for (int i = 0; i < int'(centroid_num); i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      dump_done_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          overflow_q  <= (bus.clear ? 1'b0 : overflow_q)  | sat_c;
          index_err_q <= (bus.clear ? 1'b0 : index_err_q) | bad_idx_c;
          if (bus.dump_req) begin
            if (first_ok_c) begin
              state_q      <= DUMP;
              in_ready_q   <= 1'b0;
              dump_valid_q <= 1'b1;
              dump_index_q <= IDX_W'(first_slot_c) + IDX_W'(1);
              dump_accum_q <= sum_d[first_slot_c];
              dump_count_q <= cnt_d[first_slot_c];
            end else begin
              dump_done_q  <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (dump_valid_q && bus.dump_ready) begin
            if (nxt_ok_c) begin
              dump_index_q <= IDX_W'(nxt_slot_c) + IDX_W'(1);
              dump_accum_q <= sum_q[nxt_slot_c];
              dump_count_q <= cnt_q[nxt_slot_c];
            end else begin
              state_q      <= ACCUM;
              in_ready_q   <= 1'b1;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_index = dump_index_q;
  assign bus.dump_accum = dump_accum_q;
  assign bus.dump_count = dump_count_q;
  assign bus.dump_done  = dump_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.index_err  = index_err_q;

endmodule

// File: tb/tb_cluster_accum_pipe3.sv
// Self-checking bench for cluster_accum_pipe3: reference model of the slots feeds a
// record scoreboard that is drained as the DUT hands records over.
module tb_cluster_accum_pipe3;

  localparam int unsigned SUM_MAX = 4194303;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cluster_accum_pipe3_if bus ();

  cluster_accum_pipe3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [153:0] acc;
    logic [9:0]   cnt;
  } rec_t;

  rec_t        sbq[$];
  int unsigned m_sum [8][7];
  int unsigned m_cnt [8];
  bit          m_ovf;
  bit          m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [90:0] mkpt(input int v);
    logic [90:0] p;
    p = '0;
    for (int c = 0; c < 7; c++) p[c*13 +: 13] = 13'(v);
    return p;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_cnt[s] = 0;
      for (int c = 0; c < 7; c++) m_sum[s][c] = 0;
    end
    m_ovf = 0;
    m_err = 0;
  endtask

  task automatic model_apply(input bit clr, input bit pv, input int idx, input int v);
    int unsigned s;
    if (clr) model_reset();
    if (pv) begin
      if (idx < 1 || idx > 8) begin
        m_err = 1;
      end else begin
        for (int c = 0; c < 7; c++) begin
          s = m_sum[idx-1][c] + v;
          if (s > SUM_MAX) begin
            s = SUM_MAX;
            m_ovf = 1;
          end
          m_sum[idx-1][c] = s;
        end
        if (m_cnt[idx-1] == 1023) m_ovf = 1;
        else m_cnt[idx-1]++;
      end
    end
  endtask

  function automatic logic [153:0] exp_acc(input int s);
    logic [153:0] a;
    for (int c = 0; c < 7; c++) a[c*22 +: 22] = 22'(m_sum[s][c]);
    return a;
  endfunction

  task automatic push_expected();
    rec_t r;
    for (int s = 0; s < 8; s++) begin
`ifdef CLUSTER_ACCUM_SKIP_EMPTY_EN
      if (m_cnt[s] == 0) continue;
`endif
      r.idx = 4'(s + 1);
      r.acc = exp_acc(s);
      r.cnt = 10'(m_cnt[s]);
      sbq.push_back(r);
    end
  endtask

  task automatic do_clear(input bit pv, input int idx, input int v);
    bus.clear = 1'b1;
    bus.point_valid = pv;
    bus.index = 4'(idx);
    bus.point_from_pipe2 = mkpt(v);
    model_apply(1, pv, idx, v);
    tick();
    bus.clear = 1'b0;
    bus.point_valid = 1'b0;
  endtask

  task automatic send_pts(input int idx, input int v, input int n);
    bus.index = 4'(idx);
    bus.point_from_pipe2 = mkpt(v);
    for (int k = 0; k < n; k++) begin
      bus.point_valid = 1'b1;
      model_apply(0, 1, idx, v);
      tick();
    end
    bus.point_valid = 1'b0;
  endtask

  // Dump and drain the scoreboard; optional stall pattern, same-cycle point, reset abort.
  task automatic run_dump(input bit stall, input bit with_pt, input int abort_at);
    bit pat [4];
    int cyc;
    bit aborted;
    rec_t r;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    bus.dump_req = 1'b1;
    if (with_pt) begin
      bus.point_valid = 1'b1;
      bus.point_from_pipe2 = mkpt(11);
      bus.index = 4'd4;
      model_apply(0, 1, 4, 11);
    end
    push_expected();
    tick();
    bus.dump_req = 1'b0;
    bus.point_valid = 1'b0;
    cyc = 0;
    aborted = 0;
    while (sbq.size() != 0 && cyc < 200) begin
      if (abort_at != 0 && int'(bus.dump_index) == abort_at) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.dump_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dump_index !== 4'd1) begin
          bad++;
          $display("FAIL abort_reset: valid=%b in_ready=%b idx=%0d want 0/1/1",
                   bus.dump_valid, bus.in_ready, bus.dump_index);
        end
        sbq.delete();
        model_reset();
        for (int k = 0; k < 2; k++) begin
          tick();
          rst_n = 1'b1;
          total++;
          if (bus.dump_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got %b want 0", bus.dump_done);
          end
        end
        aborted = 1;
        break;
      end
      r = sbq[0];
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL dump_in_ready: got %b want 0", bus.in_ready);
      end
      total++;
      if (bus.dump_valid !== 1'b1) begin
        bad++;
        $display("FAIL dump_valid: got %b want 1", bus.dump_valid);
      end
      total++;
      if (bus.dump_index !== r.idx) begin
        bad++;
        $display("FAIL rec_index: got %0d want %0d", bus.dump_index, r.idx);
      end
      total++;
      if (bus.dump_accum !== r.acc) begin
        bad++;
        $display("FAIL rec_accum idx%0d: got %h want %h", r.idx, bus.dump_accum, r.acc);
      end
      total++;
      if (bus.dump_count !== r.cnt) begin
        bad++;
        $display("FAIL rec_count idx%0d: got %0d want %0d", r.idx, bus.dump_count, r.cnt);
      end
      bus.dump_ready = stall ? pat[cyc % 4] : 1'b1;
      if (stall && cyc == 1) begin
        bus.point_valid = 1'b1;
        bus.point_from_pipe2 = mkpt(50);
        bus.index = 4'd3;
        bus.clear = 1'b1;
      end
      if (bus.dump_ready) void'(sbq.pop_front());
      tick();
      bus.point_valid = 1'b0;
      bus.clear = 1'b0;
      cyc++;
    end
    bus.dump_ready = 1'b0;
    if (!aborted) begin
      total++;
      if (cyc >= 200) begin
        bad++;
        $display("FAIL dump_timeout: %0d records left", sbq.size());
        sbq.delete();
      end
      total++;
      if (bus.dump_done !== 1'b1) begin
        bad++;
        $display("FAIL dump_done: got %b want 1", bus.dump_done);
      end
      tick();
      total++;
      if (bus.dump_done !== 1'b0 || bus.in_ready !== 1'b1 || bus.dump_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_dump: done=%b in_ready=%b valid=%b want 0/1/0",
                 bus.dump_done, bus.in_ready, bus.dump_valid);
      end
    end
  endtask

  task automatic check_flags(input string tag);
    total++;
    if (bus.overflow !== m_ovf) begin
      bad++;
      $display("FAIL %s overflow: got %b want %b", tag, bus.overflow, m_ovf);
    end
    total++;
    if (bus.index_err !== m_err) begin
      bad++;
      $display("FAIL %s index_err: got %b want %b", tag, bus.index_err, m_err);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++;
    if (bus.dump_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.dump_valid); end
    total++;
    if (bus.dump_index !== 4'd1) begin bad++; $display("FAIL rst_index: got %0d want 1", bus.dump_index); end
    total++;
    if (bus.dump_accum !== '0) begin bad++; $display("FAIL rst_accum: got %h want 0", bus.dump_accum); end
    total++;
    if (bus.dump_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.dump_count); end
    total++;
    if (bus.dump_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.dump_done); end
    check_flags("rst");
  endtask

  task automatic test_basic();
    do_clear(0, 1, 0);
    send_pts(3, 5, 4);
    send_pts(8, 100, 2);
    check_flags("basic");
    run_dump(0, 0, 0);
  endtask

  task automatic test_saturation();
    do_clear(0, 1, 0);
    send_pts(1, 8191, 1024);
    check_flags("sat");
    run_dump(0, 0, 0);
  endtask

  task automatic test_index_err();
    send_pts(0, 3, 1);
    send_pts(9, 3, 1);
    check_flags("idx_err");
    run_dump(0, 0, 0);
    do_clear(0, 1, 0);
    check_flags("idx_err_clr");
  endtask

  task automatic test_clear_with_point();
    send_pts(5, 3, 2);
    send_pts(2, 9, 1);
    do_clear(1, 2, 7);
    check_flags("clr_pt");
    run_dump(0, 0, 0);
  endtask

  task automatic test_stall_abort();
    run_dump(1, 1, 5);
    run_dump(0, 0, 0);
  endtask

  task automatic test_skip_empty();
    do_clear(0, 1, 0);
    run_dump(0, 0, 0);
    send_pts(2, 1, 1);
    send_pts(6, 2, 1);
    run_dump(0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.point_from_pipe2 = '0;
    bus.index = '0;
    bus.point_valid = 1'b0;
    bus.clear = 1'b0;
    bus.dump_req = 1'b0;
    bus.dump_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_saturation();
    test_index_err();
    test_clear_with_point();
    test_stall_abort();
    test_skip_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cluster_accum_pipe3.md
Name: cluster_accum_pipe3

Overview:
- Pipe stage 3 of the K-means datapath. Consumes the winning centroid index and the delayed point from the classify stage.
- Keeps per-centroid coordinate sums and member counts for the current iteration.
- On request, streams the eight (sum, count) records to the centroid-update logic over a valid/ready handshake.

Parameters:
- dataWidth, 91, point width (coord_num x cordinate_width)
- cordinate_width, 13, unsigned width of one coordinate
- coord_num, 7, coordinates per point
- accum_cord_width, 22, width of one per-coordinate sum
- accum_width, 154, coord_num x accum_cord_width
- centroid_num, 8, number of clusters
- count_width, 10, member counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- point_from_pipe2  in  dataWidth  point; coordinate c occupies bits [13c+12:13c], c=0..6
- index  in  4  winning centroid, legal range 1..8
- point_valid  in  1  point/index pair present this cycle
- in_ready  out  1  block accepts points (high in ACCUM)
- clear  in  1  start of iteration: zero all sums and counts
- dump_req  in  1  one-cycle pulse, start readout
- dump_valid  out  1  readout record valid
- dump_ready  in  1  downstream accepts record
- dump_index  out  4  centroid number of current record (1..8)
- dump_accum  out  accum_width  sums; coordinate c in bits [22c+21:22c]
- dump_count  out  count_width  member count
- dump_done  out  1  one-cycle pulse after last record accepted
- overflow  out  1  sticky: a sum or count saturated
- index_err  out  1  sticky: valid point with index 0 or >8

Behaviour:
- Reset values: all sums/counts 0, state ACCUM, in_ready=1, dump_valid=0, dump_index=1, dump_accum=0, dump_count=0, dump_done=0, overflow=0, index_err=0.
- States: ACCUM, DUMP.
- ACCUM:
  - A point is accepted when point_valid & in_ready.
  - On acceptance, slot index-1 adds each coordinate zero-extended to 22 bits and increments its count.
  - Result is visible to a dump starting on the next edge (1-cycle latency).
- Illegal index: point dropped, no slot changes, index_err set.
- Saturation:
  - Each coordinate sum saturates at 2^22-1 independently.
  - Count saturates at 1023.
  - Any saturation sets overflow.
- clear (ACCUM only):
  - Zeroes every slot and clears overflow and index_err in one cycle.
  - clear together with an accepted point: the addressed slot holds exactly that point, count=1; all other slots are zero.
- dump_req in ACCUM:
  - Any point accepted in the same cycle is accumulated first.
  - Next cycle: state DUMP, in_ready=0, dump_valid=1, dump_index=1.
- DUMP:
  - Outputs are registered and stable while dump_valid & !dump_ready.
  - Advances to the next index on dump_valid & dump_ready.
  - After index 8 is accepted: dump_valid=0, dump_done=1 for one cycle, return to ACCUM with in_ready=1.
  - Sums/counts are retained after dump; only clear zeroes them.
- In DUMP, clear, dump_req and point_valid are ignored. in_ready=0, so no point is lost by a compliant producer.
- dump_req while already in DUMP: ignored, no restart.
- Reset mid-dump: immediate return to reset values, no dump_done.

Optional Feature:
- Macro CLUSTER_ACCUM_SKIP_EMPTY_EN.
- Defined:
  - DUMP presents only slots with count != 0, in ascending index order.
  - If all slots are empty, dump_done pulses the cycle after dump_req with no dump_valid.
- Undefined: all 8 records are always presented, including zero-count records.

Test Plan:
- Reset, clear, then points with all coords 5 to index 3 (x4), coords 100 to index 8 (x2), then dump with dump_ready=1. Expect 8 records: idx3 sums 20/count 4, idx8 sums 200/count 2, all others 0/0. dump_done pulses one cycle after idx8 is accepted.
- 1023 points of coords 8191 to index 1, then a 1024th. Expect count=1023, each sum = min(1024*8191, 4194303) = 4194303, overflow=1.
- index=0 and index=9 with point_valid. Expect index_err=1 and all slots unchanged. A following clear drops index_err to 0.
- clear and a valid point (coords 7, index 2) in the same cycle after prior accumulation. Expect idx2 = 7/1 and all others 0.
- Dump with dump_ready toggling 1,0,0,1 per cycle. Expect dump_index/data held during the stalls, in_ready=0 throughout, a point_valid pulse during DUMP not accumulated, and rst_n low at record 5 aborting with no dump_done.
- With CLUSTER_ACCUM_SKIP_EMPTY_EN, only idx 2 and 6 populated. Expect exactly two records (2, then 6), then dump_done.
